// File: rtl/sound_pkt_writer_if.sv
// Bundle of signals between the audio sample source, the packet RAM write port,
// the serial transmitter's completion pulse and the status outputs.
interface sound_pkt_writer_if #(
  parameter int PKT_BYTES = 2048,
  parameter int NUM_BUF   = 4
);
  localparam int ADDR_W = $clog2(NUM_BUF) + $clog2(PKT_BYTES);

  logic               smp_valid;
  logic [15:0]        smp_data;
  logic               smp_ready;
  logic               packet_SENT;
  logic [ADDR_W-1:0]  wraddress;
  logic [7:0]         wrdata;
  logic               wren;
  logic [NUM_BUF-1:0] buff_RDY;
  logic               overflow;
  logic [15:0]        drop_cnt;

  // Sample source / transmitter / RAM side.
  modport master (
    output smp_valid, smp_data, packet_SENT,
    input  smp_ready, wraddress, wrdata, wren, buff_RDY, overflow, drop_cnt
  );

  // Packet writer side.
  modport slave (
    input  smp_valid, smp_data, packet_SENT,
    output smp_ready, wraddress, wrdata, wren, buff_RDY, overflow, drop_cnt
  );
endinterface

// File: rtl/sound_pkt_writer.sv
// Splits 16-bit audio samples into two byte writes (low byte first) into a
// ring of NUM_BUF packet slots of PKT_BYTES bytes each. A slot is flagged
// ready when its last byte is written and released by the transmitter's
// packet_SENT pulse; samples arriving while busy or with no free slot are
// counted as drops.
module sound_pkt_writer #(
  parameter int PKT_BYTES = 2048,
  parameter int NUM_BUF   = 4
) (
  input logic               clock,
  input logic               reset,
  sound_pkt_writer_if.slave bus
);
  localparam int OFF_W  = $clog2(PKT_BYTES);
  localparam int SLOT_W = $clog2(NUM_BUF);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SLOT_W-1:0]  wr_slot;
  logic [SLOT_W-1:0]  rd_slot;
  logic [OFF_W-1:0]   offset;
  logic [15:0]        smp_latch;
  logic               accept;
  logic               drop;
  logic               pkt_done;
  logic               pkt_free;
  logic [NUM_BUF-1:0] set_mask;
  logic [NUM_BUF-1:0] clr_mask;

  assign bus.smp_ready = (state == IDLE) && !bus.buff_RDY[wr_slot];
  assign accept        = bus.smp_valid && bus.smp_ready;
  assign drop          = bus.smp_valid && !bus.smp_ready;
  // In WR_HI the registered address is the high byte just written, so it
  // tells directly whether this write closed the slot.
  assign pkt_done      = (state == WR_HI) &&
                         (bus.wraddress[OFF_W-1:0] == OFF_W'(PKT_BYTES - 1));
  assign pkt_free      = bus.packet_SENT && bus.buff_RDY[rd_slot];

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: one sample takes IDLE -> WR_LO -> WR_HI -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WR_LO;
      WR_LO:   state_nxt = WR_HI;
      WR_HI:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM write port: low byte the cycle after acceptance, high byte the next.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.wren      <= 1'b0;
      bus.wraddress <= '0;
      bus.wrdata    <= '0;
      smp_latch     <= '0;
      offset        <= '0;
    end else begin
      bus.wren <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            smp_latch     <= bus.smp_data;
            bus.wren      <= 1'b1;
            bus.wraddress <= {wr_slot, offset};
            bus.wrdata    <= bus.smp_data[7:0];
          end
        end
        WR_LO: begin
          bus.wren      <= 1'b1;
          bus.wraddress <= {wr_slot, offset + OFF_W'(1)};
          bus.wrdata    <= smp_latch[15:8];
          offset        <= (offset == OFF_W'(PKT_BYTES - 2)) ? '0 : offset + OFF_W'(2);
        end
        default: ;
      endcase
    end
  end

  // Set/clear masks for the ready flags; a set and a clear never hit the same bit.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (pkt_done) set_mask[wr_slot] = 1'b1;
    if (pkt_free) clr_mask[rd_slot] = 1'b1;
  end

  // Slot ring: flags plus write/read slot pointers advancing in strict order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.buff_RDY <= '0;
      wr_slot      <= '0;
      rd_slot      <= '0;
    end else begin
      bus.buff_RDY <= (bus.buff_RDY | set_mask) & ~clr_mask;
      if (pkt_done)
        wr_slot <= (wr_slot == SLOT_W'(NUM_BUF - 1)) ? '0 : wr_slot + SLOT_W'(1);
      if (pkt_free)
        rd_slot <= (rd_slot == SLOT_W'(NUM_BUF - 1)) ? '0 : rd_slot + SLOT_W'(1);
    end
  end

  // Drop accounting: sticky overflow and a saturating drop counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.overflow <= 1'b0;
      bus.drop_cnt <= '0;
    end else if (drop) begin
      bus.overflow <= 1'b1;
      if (bus.drop_cnt != 16'hFFFF) bus.drop_cnt <= bus.drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_sound_pkt_writer.sv
// Bench for sound_pkt_writer: a byte-address/queue model of the packet ring
// predicts every output each cycle; directed steps add literal expectations.
module tb_sound_pkt_writer;
  localparam int PKT_BYTES = 2048;
  localparam int NUM_BUF   = 4;
  localparam int RING      = PKT_BYTES * NUM_BUF;

  logic clock = 1'b0;
  logic reset = 1'b0;

  sound_pkt_writer_if #(.PKT_BYTES(PKT_BYTES), .NUM_BUF(NUM_BUF)) bus ();

  sound_pkt_writer #(.PKT_BYTES(PKT_BYTES), .NUM_BUF(NUM_BUF)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  int         m_wptr   = 0;      // linear byte address of the next low byte
  int         m_busy   = 0;      // cycles left before the writer is idle again
  bit         m_closing = 1'b0;  // the sample in flight fills its slot
  int         m_cslot  = 0;
  int         m_full[$];         // slots waiting for transmission, oldest first
  int         m_pa[$];           // pending write addresses
  logic [7:0] m_pd[$];           // pending write bytes
  bit         m_wren   = 1'b0;
  int         m_addr   = 0;
  logic [7:0] m_data   = '0;
  bit         m_ovf    = 1'b0;
  int         m_drop   = 0;
  bit         m_rdy_pre;

  function automatic logic [NUM_BUF-1:0] full_mask();
    logic [NUM_BUF-1:0] m;
    m = '0;
    foreach (m_full[i]) m[m_full[i]] = 1'b1;
    return m;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_wptr = 0; m_busy = 0; m_closing = 1'b0; m_cslot = 0;
      m_full.delete(); m_pa.delete(); m_pd.delete();
      m_wren = 1'b0; m_addr = 0; m_data = '0; m_ovf = 1'b0; m_drop = 0;
    end else begin
      m_rdy_pre = (m_busy == 0) && (m_full.size() < NUM_BUF);
      if (bus.packet_SENT && m_full.size() > 0) void'(m_full.pop_front());
      if (m_busy == 1 && m_closing) begin
        m_full.push_back(m_cslot);
        m_closing = 1'b0;
      end
      if (m_busy > 0) m_busy--;
      if (bus.smp_valid) begin
        if (m_rdy_pre) begin
          m_pa.push_back(m_wptr);     m_pd.push_back(bus.smp_data[7:0]);
          m_pa.push_back(m_wptr + 1); m_pd.push_back(bus.smp_data[15:8]);
          if ((m_wptr + 1) % PKT_BYTES == PKT_BYTES - 1) begin
            m_closing = 1'b1;
            m_cslot   = m_wptr / PKT_BYTES;
          end
          m_wptr = (m_wptr + 2) % RING;
          m_busy = 2;
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
      if (m_pa.size() > 0) begin
        m_wren = 1'b1;
        m_addr = m_pa.pop_front();
        m_data = m_pd.pop_front();
      end else begin
        m_wren = 1'b0;
      end
    end
  end

  // ---------------- literal expectations posted by the stimulus ----------------
  string       lit_tag = "init";
  logic [6:0]  lit_m = '0;   // wren, addr, data, buff, ovf, drop, rdy
  logic        lit_wren = 1'b0;
  logic [12:0] lit_addr = '0;
  logic [7:0]  lit_data = '0;
  logic [3:0]  lit_buff = '0;
  logic        lit_ovf = 1'b0;
  logic [15:0] lit_drop = '0;
  logic        lit_rdy = 1'b0;

  // ---------------- compare process ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    chk("wren", 32'(bus.wren), 32'(m_wren));
    if (m_wren) begin
      chk("wraddress", 32'(bus.wraddress), 32'(m_addr));
      chk("wrdata", 32'(bus.wrdata), 32'(m_data));
    end
    chk("buff_RDY", 32'(bus.buff_RDY), 32'(full_mask()));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    chk("smp_ready", 32'(bus.smp_ready), 32'((m_busy == 0) && (m_full.size() < NUM_BUF)));
    if (lit_m[0]) chk({lit_tag, ".wren"}, 32'(bus.wren), 32'(lit_wren));
    if (lit_m[1]) chk({lit_tag, ".addr"}, 32'(bus.wraddress), 32'(lit_addr));
    if (lit_m[2]) chk({lit_tag, ".data"}, 32'(bus.wrdata), 32'(lit_data));
    if (lit_m[3]) chk({lit_tag, ".buff"}, 32'(bus.buff_RDY), 32'(lit_buff));
    if (lit_m[4]) chk({lit_tag, ".ovf"}, 32'(bus.overflow), 32'(lit_ovf));
    if (lit_m[5]) chk({lit_tag, ".drop"}, 32'(bus.drop_cnt), 32'(lit_drop));
    if (lit_m[6]) chk({lit_tag, ".rdy"}, 32'(bus.smp_ready), 32'(lit_rdy));
  end

  // ---------------- stimulus helpers ----------------
  task automatic want_wren(input logic v);         lit_wren = v; lit_m[0] = 1'b1; endtask
  task automatic want_addr(input logic [12:0] v);  lit_addr = v; lit_m[1] = 1'b1; endtask
  task automatic want_data(input logic [7:0] v);   lit_data = v; lit_m[2] = 1'b1; endtask
  task automatic want_buff(input logic [3:0] v);   lit_buff = v; lit_m[3] = 1'b1; endtask
  task automatic want_ovf(input logic v);          lit_ovf  = v; lit_m[4] = 1'b1; endtask
  task automatic want_drop(input logic [15:0] v);  lit_drop = v; lit_m[5] = 1'b1; endtask
  task automatic want_rdy(input logic v);          lit_rdy  = v; lit_m[6] = 1'b1; endtask

  task automatic step();
    @(posedge clock);
    #1;
    lit_m = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [15:0] d);
    bus.smp_valid = 1'b1;
    bus.smp_data  = d;
    step();
    bus.smp_valid = 1'b0;
  endtask

  task automatic put(input logic [15:0] d);
    send(d);
    idle(2);
  endtask

  task automatic want_all_zero();
    want_wren(1'b0); want_addr(13'd0); want_data(8'd0); want_buff(4'd0);
    want_ovf(1'b0); want_drop(16'd0); want_rdy(1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.smp_valid   = 1'b0;
    bus.smp_data    = '0;
    bus.packet_SENT = 1'b0;
    reset           = 1'b0;
    step();
    lit_tag = "reset";
    want_all_zero();
    step();
    reset = 1'b1;
    idle(2);

    // Single sample: low byte then high byte, then idle.
    lit_tag = "single";
    send(16'hA55A);
    want_wren(1'b1); want_addr(13'd0); want_data(8'h5A); want_rdy(1'b0);
    step();
    want_wren(1'b1); want_addr(13'd1); want_data(8'hA5);
    step();
    want_wren(1'b0); want_rdy(1'b1);

    // Complete the first slot.
    for (int i = 1; i < 1023; i++) put(16'(i));
    lit_tag = "pkt0_end";
    send(16'hBEEF);
    want_addr(13'd2046); want_data(8'hEF);
    step();
    want_addr(13'd2047); want_data(8'hBE); want_buff(4'b0000);
    step();
    want_buff(4'b0001); want_wren(1'b0);

    lit_tag = "pkt1_start";
    send(16'h1234);
    want_wren(1'b1); want_addr(13'd2048); want_data(8'h34);
    idle(2);

    // Fill all four slots with nothing transmitted.
    for (int i = 0; i < 3071; i++) put(16'(i * 7 + 3));
    lit_tag = "all_full";
    want_buff(4'b1111); want_rdy(1'b0); want_ovf(1'b0);
    for (int i = 0; i < 3; i++) begin
      send(16'hDEAD);
      want_wren(1'b0);
    end
    want_ovf(1'b1); want_drop(16'd3); want_buff(4'b1111);

    // One slot transmitted: writing resumes at slot 0.
    lit_tag = "sent_one";
    bus.packet_SENT = 1'b1;
    step();
    bus.packet_SENT = 1'b0;
    want_buff(4'b1110); want_rdy(1'b1);
    send(16'h0F0F);
    want_wren(1'b1); want_addr(13'd0); want_data(8'h0F);
    idle(2);

    // A sample arriving during the low-byte write is dropped.
    lit_tag = "drop_wrlo";
    send(16'h5555);
    want_rdy(1'b0);
    bus.smp_valid = 1'b1;
    bus.smp_data  = 16'h7777;
    step();
    bus.smp_valid = 1'b0;
    want_drop(16'd4); want_addr(13'd3); want_data(8'h55);
    idle(1);

    // Drain the remaining slots, then a spurious packet_SENT.
    lit_tag = "drain";
    for (int i = 0; i < 3; i++) begin
      bus.packet_SENT = 1'b1;
      step();
    end
    bus.packet_SENT = 1'b0;
    want_buff(4'b0000);
    lit_tag = "sent_empty";
    bus.packet_SENT = 1'b1;
    step();
    bus.packet_SENT = 1'b0;
    want_buff(4'b0000); want_drop(16'd4); want_ovf(1'b1);
    idle(2);

    // Reset during the high-byte write of the slot-closing sample.
    lit_tag = "rst_mid";
    reset = 1'b0;
    step();
    reset = 1'b1;
    idle(1);
    for (int i = 0; i < 1023; i++) put(16'(i ^ 16'h3C3C));
    send(16'hCAFE);
    step();
    want_all_zero();
    #3;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    idle(3);
    lit_tag = "after_rst";
    want_buff(4'b0000); want_rdy(1'b1);
    send(16'h4321);
    want_wren(1'b1); want_addr(13'd0); want_data(8'h21);
    idle(2);
    want_buff(4'b0000);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
